ws_sys_array: RTL and testbench



---
 rtl/ws_sys_array.sv | 213 +++++++++++++++++++++
 tb/tb_ws_sys_array.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ws_sys_array.sv
// Weight-stationary ROWS x COLS systolic mesh with internal input skew and output deskew.
// Two weight banks allow a new matrix to load while vectors tagged with the other bank drain.
module ws_sys_array #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int IN_W  = 8,
  parameter int ACC_W = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [COLS*IN_W-1:0]  w_data,
  input  logic                  act_valid,
  input  logic [ROWS*IN_W-1:0]  act_data,
  output logic                  out_valid,
  output logic [COLS*ACC_W-1:0] out_data,
  output logic                  active_bank
);
  localparam int L  = ROWS + COLS - 1;
  localparam int CW = $clog2(L + 2);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int WB = ROWS * COLS * IN_W;

  logic [RW-1:0] wload_cnt_q, wload_cnt_d;
  logic          active_bank_q, active_bank_d;
  logic [WB-1:0] wb0_q, wb0_d, wb1_q, wb1_d;
  logic [CW-1:0] infl0_q, infl0_d, infl1_q, infl1_d;
  logic          w_fire_s, out_tag_s;

  // The shadow bank may only be rewritten once no vector tagged with it is still in flight.
  assign w_ready     = !reset && (active_bank_q ? (infl0_q == '0) : (infl1_q == '0));
  assign w_fire_s    = w_valid && w_ready;
  assign active_bank = active_bank_q;

  // Weight row write into the shadow bank, bank swap on the final row, in-flight accounting.
  always_comb begin
    wload_cnt_d   = wload_cnt_q;
    active_bank_d = active_bank_q;
    wb0_d         = wb0_q;
    wb1_d         = wb1_q;
    if (w_fire_s) begin
      for (int j = 0; j < COLS; j++) begin
        if (active_bank_q) begin
          wb0_d[(int'(wload_cnt_q) * COLS + j) * IN_W +: IN_W] = w_data[j*IN_W +: IN_W];
        end else begin
          wb1_d[(int'(wload_cnt_q) * COLS + j) * IN_W +: IN_W] = w_data[j*IN_W +: IN_W];
        end
      end
      if (wload_cnt_q == RW'(ROWS - 1)) begin
        wload_cnt_d   = '0;
        active_bank_d = !active_bank_q;
      end else begin
        wload_cnt_d   = wload_cnt_q + 1'b1;
      end
    end else begin
      wload_cnt_d = wload_cnt_q;
    end
    infl0_d = infl0_q + CW'(act_valid && !active_bank_q) - CW'(out_valid && !out_tag_s);
    infl1_d = infl1_q + CW'(act_valid &&  active_bank_q) - CW'(out_valid &&  out_tag_s);
  end

  // Bank storage and load control registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wload_cnt_q   <= '0;
      active_bank_q <= 1'b0;
      wb0_q         <= '0;
      wb1_q         <= '0;
      infl0_q       <= '0;
      infl1_q       <= '0;
    end else begin
      wload_cnt_q   <= wload_cnt_d;
      active_bank_q <= active_bank_d;
      wb0_q         <= wb0_d;
      wb1_q         <= wb1_d;
      infl0_q       <= infl0_d;
      infl1_q       <= infl1_d;
    end
  end

  // Row i enters column 0 after i cycles; row 0 feeds the mesh straight from the port.
  logic [ROWS*IN_W-1:0] row_a_s;
  logic [ROWS-1:0]      row_v_s, row_t_s;

  assign row_a_s[IN_W-1:0] = act_data[IN_W-1:0];
  assign row_v_s[0]        = act_valid;
  assign row_t_s[0]        = active_bank_q;

  for (genvar i = 1; i < ROWS; i++) begin : g_skew
    logic [IN_W-1:0] sa_q [i];
    logic [IN_W-1:0] sa_d [i];
    logic [i-1:0]    sv_q, sv_d, st_q, st_d;

    // Skew shift chain for row i carrying data, valid and bank tag together.
    always_comb begin
      sa_d[0] = act_data[i*IN_W +: IN_W];
      sv_d    = '0;
      st_d    = '0;
      sv_d[0] = act_valid;
      st_d[0] = active_bank_q;
      for (int k = 1; k < i; k++) begin
        sa_d[k] = sa_q[k-1];
        sv_d[k] = sv_q[k-1];
        st_d[k] = st_q[k-1];
      end
    end

    // Skew registers; reset drops any vector still in the chain.
    always_ff @(posedge clock) begin
      if (reset) begin
        for (int k = 0; k < i; k++) sa_q[k] <= '0;
        sv_q <= '0;
        st_q <= '0;
      end else begin
        sa_q <= sa_d;
        sv_q <= sv_d;
        st_q <= st_d;
      end
    end

    assign row_a_s[i*IN_W +: IN_W] = sa_q[i-1];
    assign row_v_s[i]              = sv_q[i-1];
    assign row_t_s[i]              = st_q[i-1];
  end

  logic [IN_W-1:0]  a_q [ROWS][COLS];
  logic [IN_W-1:0]  a_d [ROWS][COLS];
  logic             v_q [ROWS][COLS];
  logic             v_d [ROWS][COLS];
  logic             t_q [ROWS][COLS];
  logic             t_d [ROWS][COLS];
  logic [ACC_W-1:0] p_q [ROWS][COLS];
  logic [ACC_W-1:0] p_d [ROWS][COLS];

  // PE datapath: activation hops east, partial sum flows south, weight chosen by the travelling tag.
  always_comb begin
    logic [IN_W-1:0]          a_in_s;
    logic                     v_in_s, t_in_s;
    logic [ACC_W-1:0]         p_in_s;
    logic signed [IN_W-1:0]   w_s;
    logic signed [2*IN_W-1:0] prod_s;
    logic signed [ACC_W-1:0]  ext_s;
    int                       im, jm;
    for (int i = 0; i < ROWS; i++) begin
      for (int j = 0; j < COLS; j++) begin
        im      = (i == 0) ? 0 : i - 1;
        jm      = (j == 0) ? 0 : j - 1;
        a_in_s  = (j == 0) ? row_a_s[i*IN_W +: IN_W] : a_q[i][jm];
        v_in_s  = (j == 0) ? row_v_s[i] : v_q[i][jm];
        t_in_s  = (j == 0) ? row_t_s[i] : t_q[i][jm];
        p_in_s  = (i == 0) ? '0 : p_q[im][j];
        w_s     = t_in_s ? wb1_q[(i*COLS + j)*IN_W +: IN_W] : wb0_q[(i*COLS + j)*IN_W +: IN_W];
        prod_s  = $signed(a_in_s) * w_s;
        ext_s   = prod_s;
        a_d[i][j] = a_in_s;
        v_d[i][j] = v_in_s;
        t_d[i][j] = t_in_s;
        p_d[i][j] = p_in_s + (v_in_s ? ext_s : '0);
      end
    end
  end

  // Mesh pipeline registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ROWS; i++) begin
        for (int j = 0; j < COLS; j++) begin
          a_q[i][j] <= '0;
          v_q[i][j] <= 1'b0;
          t_q[i][j] <= 1'b0;
          p_q[i][j] <= '0;
        end
      end
    end else begin
      a_q <= a_d;
      v_q <= v_d;
      t_q <= t_d;
      p_q <= p_d;
    end
  end

  // The bottom-right PE finishes last, so its valid and tag describe the aligned output row.
  assign out_valid = v_q[ROWS-1][COLS-1];
  assign out_tag_s = t_q[ROWS-1][COLS-1];

  for (genvar j = 0; j < COLS; j++) begin : g_deskew
    if (j == COLS - 1) begin : g_direct
      assign out_data[j*ACC_W +: ACC_W] = p_q[ROWS-1][j];
    end else begin : g_delay
      localparam int D = COLS - 1 - j;
      logic [ACC_W-1:0] dq_q [D];
      logic [ACC_W-1:0] dq_d [D];

      // Deskew chain so earlier columns wait for the last one.
      always_comb begin
        dq_d[0] = p_q[ROWS-1][j];
        for (int k = 1; k < D; k++) dq_d[k] = dq_q[k-1];
      end

      // Deskew registers.
      always_ff @(posedge clock) begin
        if (reset) begin
          for (int k = 0; k < D; k++) dq_q[k] <= '0;
        end else begin
          dq_q <= dq_d;
        end
      end

      assign out_data[j*ACC_W +: ACC_W] = dq_q[D-1];
    end
  end
endmodule

// File: tb/tb_ws_sys_array.sv
// Directed plus random bench for ws_sys_array using a matrix-level reference model
// that predicts each result vector, its arrival cycle and the w_ready level.
module tb_ws_sys_array;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int IN_W  = 8;
  localparam int ACC_W = 16;
  localparam int L     = ROWS + COLS - 1;

  logic                  clock = 1'b0;
  logic                  reset, w_valid, w_ready, act_valid, out_valid, active_bank;
  logic [COLS*IN_W-1:0]  w_data;
  logic [ROWS*IN_W-1:0]  act_data;
  logic [COLS*ACC_W-1:0] out_data;

  always #5 clock = ~clock;

  ws_sys_array #(.ROWS(ROWS), .COLS(COLS), .IN_W(IN_W), .ACC_W(ACC_W)) dut (
    .clock(clock), .reset(reset),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .act_valid(act_valid), .act_data(act_data),
    .out_valid(out_valid), .out_data(out_data), .active_bank(active_bank)
  );

  typedef struct {
    int                    due;
    bit                    tag;
    logic [COLS*ACC_W-1:0] vec;
  } exp_t;

  exp_t q[$];
  int   wm [2][ROWS][COLS];
  bit   m_bank;
  int   m_cnt;
  int   ecount;
  int   total;
  int   bad;

  function automatic logic [COLS*ACC_W-1:0] mat_vec(input logic [ROWS*IN_W-1:0] a, input bit b);
    logic [COLS*ACC_W-1:0] r;
    int s;
    for (int j = 0; j < COLS; j++) begin
      s = 0;
      for (int i = 0; i < ROWS; i++) s += $signed(a[i*IN_W +: IN_W]) * wm[b][i][j];
      r[j*ACC_W +: ACC_W] = s[ACC_W-1:0];
    end
    return r;
  endfunction

  function automatic logic [COLS*IN_W-1:0] row_of(input int kind, input int r);
    logic [COLS*IN_W-1:0] v;
    int e;
    for (int j = 0; j < COLS; j++) begin
      case (kind)
        0:       e = r + j;
        1:       e = (r == j) ? 1 : 0;
        2:       e = 1;
        3:       e = 2;
        default: e = -128;
      endcase
      v[j*IN_W +: IN_W] = e[IN_W-1:0];
    end
    return v;
  endfunction

  function automatic logic [ROWS*IN_W-1:0] vec4(input int a0, input int a1, input int a2, input int a3);
    logic [ROWS*IN_W-1:0] v;
    int e [4];
    e = '{a0, a1, a2, a3};
    for (int i = 0; i < ROWS; i++) v[i*IN_W +: IN_W] = e[i][IN_W-1:0];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs mid-cycle against the model, advance the model, cross the edge.
  task automatic tick();
    bit   exp_rdy;
    bit   exp_ov;
    exp_t e;
    @(negedge clock);
    exp_rdy = !reset;
    foreach (q[k]) if (q[k].tag != m_bank) exp_rdy = 1'b0;
    chk("w_ready", w_ready, exp_rdy);
    chk("active_bank", active_bank, m_bank);
    exp_ov = (q.size() > 0) && (q[0].due == ecount);
    chk("out_valid", out_valid, exp_ov);
    if (exp_ov) begin
      chk("out_data", out_data, q[0].vec);
      void'(q.pop_front());
    end
    if (reset) begin
      q.delete();
      foreach (wm[b, i, j]) wm[b][i][j] = 0;
      m_bank = 1'b0;
      m_cnt  = 0;
    end else begin
      if (act_valid) begin
        e.due = ecount + L;
        e.tag = m_bank;
        e.vec = mat_vec(act_data, m_bank);
        q.push_back(e);
      end
      if (w_valid && exp_rdy) begin
        for (int j = 0; j < COLS; j++) wm[!m_bank][m_cnt][j] = $signed(w_data[j*IN_W +: IN_W]);
        if (m_cnt == ROWS - 1) begin
          m_cnt  = 0;
          m_bank = !m_bank;
        end else begin
          m_cnt++;
        end
      end
    end
    @(posedge clock);
    ecount++;
    #1;
  endtask

  task automatic load(input int kind, input bit gap);
    bit start;
    int g;
    start = m_bank;
    g = 0;
    while (m_bank == start && g < 200) begin
      w_valid = gap ? (g[0] == 1'b0) : 1'b1;
      w_data  = row_of(kind, m_cnt);
      tick();
      g++;
    end
    w_valid = 1'b0;
    total++;
    assert (m_bank != start)
    else begin
      bad++;
      $error("FAIL load_timeout observed=%0d cycles expected=swap", g);
    end
  endtask

  task automatic idle(input int n);
    act_valid = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    total = 0; bad = 0; ecount = 0; m_bank = 1'b0; m_cnt = 0;
    foreach (wm[b, i, j]) wm[b][i][j] = 0;
    reset = 1'b1; w_valid = 1'b0; w_data = '0; act_valid = 1'b0; act_data = '0;
    @(posedge clock);
    #1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_valid", out_valid, 1'b0);

    // Identity weights (beats with gaps): vector must come back unchanged after L cycles.
    load(1, 1'b1);
    act_valid = 1'b1; act_data = vec4(3, -5, 7, -1);
    tick();
    idle(L + 2);

    // Streaming: W[i][j] = i+j, eight back-to-back vectors [n,n,n,n].
    load(0, 1'b0);
    for (int n = 1; n <= 8; n++) begin
      act_valid = 1'b1; act_data = vec4(n, n, n, n);
      tick();
    end
    idle(L + 3);

    // Swap mid-stream: all-ones, then all-twos loaded under a continuous stream,
    // then a third load held on w_valid that must wait for the old bank to drain.
    load(2, 1'b0);
    act_valid = 1'b1; act_data = vec4(1, 1, 1, 1);
    tick(); tick(); tick();
    load(3, 1'b0);
    load(0, 1'b0);
    idle(L + 3);

    // Wrap-around of the 16-bit accumulator.
    load(4, 1'b0);
    act_valid = 1'b1; act_data = vec4(-128, -128, -128, -128);
    tick();
    act_data = vec4(-128, 0, 0, 0);
    tick();
    idle(L + 3);

    // Random traffic on both ports.
    for (int c = 0; c < 300; c++) begin
      act_valid = 1'($urandom_range(0, 1));
      act_data  = $urandom;
      w_valid   = 1'($urandom_range(0, 1));
      w_data    = $urandom;
      tick();
    end
    w_valid = 1'b0;
    idle(L + 3);

    // Reset with vectors in flight and a partial load: nothing emerges, weights read as zero.
    act_valid = 1'b1; act_data = $urandom;
    w_valid = 1'b1; w_data = row_of(2, m_cnt);
    tick();
    act_data = $urandom; w_data = row_of(2, m_cnt);
    tick();
    w_valid = 1'b0; act_data = $urandom;
    tick();
    act_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("post_reset_bank", active_bank, 1'b0);
    idle(3);
    act_valid = 1'b1; act_data = vec4(5, -7, 9, 11);
    tick();
    idle(L + 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
